pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC selection for the MIPS fetch stage. The block also holds the boot and flush
// sequencing state and owns the EPC register.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        PC_CLK,
    input  logic        PC_RST,
    input  logic [31:0] PC_CUR,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    input  logic        EXC_REQ,
    input  logic        ERET,
    output logic [31:0] PC_NEXT,
    output logic [31:0] EPC,
    output logic        EXC_ACK,
    output logic        FLUSH,
    output logic [1:0]  SEQ_STATE
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [15:0] BOOT_LOAD  = 16'(BOOT_CYCLES - 1);
    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_next_d;
    logic        exc_ack_d;
    logic        flush_d;
    logic [31:0] pc_seq;

    // PC + 4 wraps naturally at 2^32.
    assign pc_seq = PC_CUR + 32'd4;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        pc_next_d = pc_seq;
        exc_ack_d = 1'b0;
        flush_d   = 1'b0;
        case (state_q)
            S_BOOT: begin
                pc_next_d = RESET_VECTOR;
                flush_d   = 1'b1;
                if (cnt_q == 16'd0) state_d = S_RUN;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_RUN: begin
                if (EXC_REQ) begin
                    pc_next_d = EXC_VECTOR;
                    epc_d     = {PC_CUR[31:2], 2'b00};
                    exc_ack_d = 1'b1;
                    cnt_d     = FLUSH_LOAD;
                    state_d   = S_FLUSH;
                end else if (ERET) begin
                    pc_next_d = {epc_q[31:2], 2'b00};
                    cnt_d     = FLUSH_LOAD;
                    state_d   = S_FLUSH;
                end else if (STALL) begin
                    // The requester keeps JUMP/BR_TAKEN asserted until the stall clears.
                    pc_next_d = PC_CUR;
                end else if (JUMP) begin
                    pc_next_d = {JUMP_TARGET[31:2], 2'b00};
                    cnt_d     = 16'd0;
                    state_d   = S_FLUSH;
                end else if (BR_TAKEN) begin
                    pc_next_d = {BR_TARGET[31:2], 2'b00};
                    cnt_d     = 16'd0;
                    state_d   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (STALL) begin
                    pc_next_d = PC_CUR;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                pc_next_d = RESET_VECTOR;
                flush_d   = 1'b1;
                cnt_d     = BOOT_LOAD;
                state_d   = S_BOOT;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge PC_CLK or negedge PC_RST) begin
        if (!PC_RST) begin
            state_q <= S_BOOT;
            cnt_q   <= BOOT_LOAD;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign PC_NEXT   = pc_next_d;
    assign EXC_ACK   = exc_ack_d;
    assign FLUSH     = flush_d;
    assign EPC       = epc_q;
    assign SEQ_STATE = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. A small PC register in the stimulus feeds PC_NEXT back
// into PC_CUR, and every check compares against a hand-computed constant.
module tb_pc_sequencer;

    logic        PC_CLK = 1'b0;
    logic        PC_RST;
    logic [31:0] PC_CUR;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        JUMP;
    logic [31:0] JUMP_TARGET;
    logic        EXC_REQ;
    logic        ERET;
    logic [31:0] PC_NEXT;
    logic [31:0] EPC;
    logic        EXC_ACK;
    logic        FLUSH;
    logic [1:0]  SEQ_STATE;

    int vectors     = 0;
    int miscompares = 0;

    pc_sequencer dut (
        .PC_CLK      (PC_CLK),
        .PC_RST      (PC_RST),
        .PC_CUR      (PC_CUR),
        .STALL       (STALL),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .JUMP        (JUMP),
        .JUMP_TARGET (JUMP_TARGET),
        .EXC_REQ     (EXC_REQ),
        .ERET        (ERET),
        .PC_NEXT     (PC_NEXT),
        .EPC         (EPC),
        .EXC_ACK     (EXC_ACK),
        .FLUSH       (FLUSH),
        .SEQ_STATE   (SEQ_STATE)
    );

    always #5 PC_CLK = ~PC_CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: the PC register captures PC_NEXT on the edge; settle #1 after it.
    task automatic tick();
        logic [31:0] latched;
        latched = PC_NEXT;
        @(posedge PC_CLK);
        #1;
        PC_CUR = latched;
        #1;
    endtask

    initial begin
        PC_RST = 1'b0; PC_CUR = 32'd0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 32'd0;
        JUMP = 1'b0; JUMP_TARGET = 32'd0; EXC_REQ = 1'b0; ERET = 1'b0;
        #2;
        check("rst_pc_next", PC_NEXT, 32'h0);
        check("rst_flush",   32'(FLUSH), 32'd1);
        check("rst_state",   32'(SEQ_STATE), 32'd0);
        check("rst_epc",     EPC, 32'h0);
        check("rst_ack",     32'(EXC_ACK), 32'd0);

        // Release between edges; BOOT lasts four edges.
        @(negedge PC_CLK);
        PC_RST = 1'b1;
        #1;
        tick(); tick(); tick();
        check("boot_state_3", 32'(SEQ_STATE), 32'd0);
        check("boot_pc_3",    PC_NEXT, 32'h0);
        tick();
        check("run_state",  32'(SEQ_STATE), 32'd1);
        check("run_flush",  32'(FLUSH), 32'd0);
        check("seq_pc_0",   PC_CUR, 32'h0);
        check("seq_next_4", PC_NEXT, 32'h4);
        tick();
        check("seq_next_8", PC_NEXT, 32'h8);
        tick();
        check("seq_next_c", PC_NEXT, 32'hC);
        tick();
        tick();
        check("seq_pc_10", PC_CUR, 32'h10);

        // Taken branch: one flush cycle.
        BR_TAKEN = 1'b1; BR_TARGET = 32'h40; #1;
        check("br_next", PC_NEXT, 32'h40);
        tick();
        BR_TAKEN = 1'b0; #1;
        check("br_flush_state", 32'(SEQ_STATE), 32'd2);
        check("br_flush",       32'(FLUSH), 32'd1);
        check("br_flush_next",  PC_NEXT, 32'h44);
        tick();
        check("br_back_run", 32'(SEQ_STATE), 32'd1);
        check("br_run_flush", 32'(FLUSH), 32'd0);

        // Exception wins over a simultaneous jump.
        PC_CUR = 32'h20; EXC_REQ = 1'b1; JUMP = 1'b1; JUMP_TARGET = 32'h100; #1;
        check("exc_next", PC_NEXT, 32'h80);
        check("exc_ack",  32'(EXC_ACK), 32'd1);
        tick();
        EXC_REQ = 1'b0; JUMP = 1'b0; #1;
        check("exc_epc",     EPC, 32'h20);
        check("exc_ack_off", 32'(EXC_ACK), 32'd0);
        check("exc_flush_1", 32'(FLUSH), 32'd1);
        check("exc_pc_cur",  PC_CUR, 32'h80);
        check("exc_next_84", PC_NEXT, 32'h84);
        tick();
        check("exc_flush_2", 32'(FLUSH), 32'd1);
        tick();
        check("exc_flush_end", 32'(FLUSH), 32'd0);
        check("exc_run",       32'(SEQ_STATE), 32'd1);

        // ERET returns to the saved PC with a two-cycle flush.
        ERET = 1'b1; #1;
        check("eret_next", PC_NEXT, 32'h20);
        check("eret_ack",  32'(EXC_ACK), 32'd0);
        tick();
        ERET = 1'b0; #1;
        check("eret_flush_1", 32'(FLUSH), 32'd1);
        check("eret_epc",     EPC, 32'h20);
        check("eret_pc_cur",  PC_CUR, 32'h20);
        tick();
        check("eret_flush_2", 32'(FLUSH), 32'd1);
        tick();
        check("eret_flush_end", 32'(FLUSH), 32'd0);

        // Stall holds the PC and blocks a taken branch until released.
        PC_CUR = 32'h30; STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h60; #1;
        check("stall_next", PC_NEXT, 32'h30);
        tick();
        check("stall_state", 32'(SEQ_STATE), 32'd1);
        check("stall_hold",  PC_CUR, 32'h30);
        STALL = 1'b0; #1;
        check("unstall_br", PC_NEXT, 32'h60);
        tick();
        BR_TAKEN = 1'b0; #1;
        check("unstall_flush", 32'(SEQ_STATE), 32'd2);

        // Stall inside FLUSH freezes the counter.
        STALL = 1'b1; #1;
        check("fl_stall_next", PC_NEXT, 32'h60);
        tick();
        check("fl_stall_state", 32'(SEQ_STATE), 32'd2);
        STALL = 1'b0; #1;
        check("fl_unstall_next", PC_NEXT, 32'h64);
        tick();
        check("fl_unstall_run", 32'(SEQ_STATE), 32'd1);

        // Wrap-around and target alignment.
        PC_CUR = 32'hFFFF_FFFC; #1;
        check("wrap_next", PC_NEXT, 32'h0);
        JUMP = 1'b1; JUMP_TARGET = 32'h203; #1;
        check("jump_align", PC_NEXT, 32'h200);
        tick();
        JUMP = 1'b0; #1;
        check("jump_flush", 32'(SEQ_STATE), 32'd2);
        tick();
        check("jump_back_run", 32'(SEQ_STATE), 32'd1);

        // Exception, then EXC_REQ left high in FLUSH is ignored, then async reset.
        PC_CUR = 32'h50; EXC_REQ = 1'b1; #1;
        check("exc2_ack", 32'(EXC_ACK), 32'd1);
        tick();
        check("exc2_epc",       EPC, 32'h50);
        check("exc2_state",     32'(SEQ_STATE), 32'd2);
        check("exc2_flush_ack", 32'(EXC_ACK), 32'd0);
        PC_RST = 1'b0; #1;
        check("arst_epc",   EPC, 32'h0);
        check("arst_state", 32'(SEQ_STATE), 32'd0);
        check("arst_ack",   32'(EXC_ACK), 32'd0);
        check("arst_flush", 32'(FLUSH), 32'd1);
        check("arst_next",  PC_NEXT, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
